// File: rtl/wb_reg_slave_if.sv
// rtl/wb_reg_slave_if.sv - Wishbone classic bus bundle between initiator and register responder
interface wb_reg_slave_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 16
);
  logic                       cyc;
  logic                       stb;
  logic                       we;
  logic [WB_ADDR_WIDTH-1:0]   adr;
  logic [WB_DATA_WIDTH-1:0]   dout;
  logic [WB_DATA_WIDTH/8-1:0] sel;
  logic [WB_DATA_WIDTH-1:0]   din;
  logic                       ack;
  logic                       err;
  logic                       rty;
  logic                       inta;

  modport master (
    output cyc, stb, we, adr, dout, sel,
    input  din, ack, err, rty, inta
  );

  modport slave (
    input  cyc, stb, we, adr, dout, sel,
    output din, ack, err, rty, inta
  );
endinterface

// File: rtl/wb_reg_slave.sv
// rtl/wb_reg_slave.sv - Wishbone classic responder: byte-selectable regs + W1C status driving inta
// Define WB_REG_SLAVE_ERR_EN to terminate out-of-range accesses with err instead of ack.
module wb_reg_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 16,
  parameter int NUM_REGS      = 8,
  parameter int WAIT_STATES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  wb_reg_slave_if.slave    wb
);
  localparam int NB    = WB_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int STAT  = NUM_REGS - 1;

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [WB_ADDR_WIDTH-1:0]  adr_q;
  logic                      we_q;
  logic [WB_DATA_WIDTH-1:0]  dat_q;
  logic [NB-1:0]             sel_q;
  logic [WB_DATA_WIDTH-1:0]  regs_q [NUM_REGS-1];
  logic [WB_DATA_WIDTH-1:0]  status_q;
  logic [WB_DATA_WIDTH-1:0]  din_q, din_d;
  logic                      ack_q, ack_d;

  logic                      acc;
  logic                      go_term;
  logic [WB_ADDR_WIDTH-1:0]  x_adr;
  logic                      x_we;
  logic [WB_DATA_WIDTH-1:0]  x_dat;
  logic [NB-1:0]             x_sel;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic [WB_DATA_WIDTH-1:0]  wmask;
  logic [WB_DATA_WIDTH-1:0]  rd_data;

  assign acc = wb.cyc & wb.stb;

  // With zero wait states the commit happens on the acceptance edge, so use live bus values then.
  assign x_adr    = (state_q == IDLE) ? wb.adr  : adr_q;
  assign x_we     = (state_q == IDLE) ? wb.we   : we_q;
  assign x_dat    = (state_q == IDLE) ? wb.dout : dat_q;
  assign x_sel    = (state_q == IDLE) ? wb.sel  : sel_q;
  assign in_range = x_adr < WB_ADDR_WIDTH'(NUM_REGS);
  assign idx      = x_adr[IDX_W-1:0];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{x_sel[b]}};
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IDX_W'(i)) rd_data = regs_q[i];
    end
    if (idx == IDX_W'(STAT)) rd_data = status_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_term = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = TERM;
            go_term = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!acc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = TERM;
          go_term = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign din_d = (go_term && !x_we && in_range) ? rd_data : '0;

`ifdef WB_REG_SLAVE_ERR_EN
  logic err_q, err_d;
  assign ack_d = go_term & in_range;
  assign err_d = go_term & ~in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign wb.err = err_q;
`else
  assign ack_d  = go_term;
  assign wb.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      if (state_q == IDLE && acc) begin
        adr_q <= wb.adr;
        we_q  <= wb.we;
        dat_q <= wb.dout;
        sel_q <= wb.sel;
      end
    end
  end

  // Register file and status share one write port, so a set and a clear never meet in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
      status_q <= '0;
    end else if (go_term && x_we && in_range) begin
      if (idx == IDX_W'(STAT)) begin
        status_q <= status_q & ~(x_dat & wmask);
      end else begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
          if (idx == IDX_W'(i)) begin
            regs_q[i]   <= (regs_q[i] & ~wmask) | (x_dat & wmask);
            status_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign wb.din  = din_q;
  assign wb.ack  = ack_q;
  assign wb.rty  = 1'b0;
  assign wb.inta = |status_q;
endmodule

// File: tb/tb_wb_reg_slave.sv
// tb/tb_wb_reg_slave.sv - directed scoreboard bench for wb_reg_slave (WAIT_STATES=1 and 3 instances)
module tb_wb_reg_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_reg_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) bus0 ();
  wb_reg_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) bus1 ();

  wb_reg_slave #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16), .NUM_REGS(8), .WAIT_STATES(1))
    dut0 (.clk(clk), .rst(rst), .wb(bus0));
  wb_reg_slave #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16), .NUM_REGS(8), .WAIT_STATES(3))
    dut1 (.clk(clk), .rst(rst), .wb(bus1));

  logic        cyc_v [2];
  logic        stb_v [2];
  logic        we_v;
  logic [31:0] adr_v;
  logic [15:0] dout_v;
  logic [1:0]  sel_v;

  assign bus0.cyc = cyc_v[0];  assign bus1.cyc = cyc_v[1];
  assign bus0.stb = stb_v[0];  assign bus1.stb = stb_v[1];
  assign bus0.we  = we_v;      assign bus1.we  = we_v;
  assign bus0.adr = adr_v;     assign bus1.adr = adr_v;
  assign bus0.dout = dout_v;   assign bus1.dout = dout_v;
  assign bus0.sel = sel_v;     assign bus1.sel = sel_v;

  logic [15:0] din_o  [2];
  logic        ack_o  [2];
  logic        err_o  [2];
  logic        rty_o  [2];
  logic        inta_o [2];
  assign din_o[0] = bus0.din;   assign din_o[1] = bus1.din;
  assign ack_o[0] = bus0.ack;   assign ack_o[1] = bus1.ack;
  assign err_o[0] = bus0.err;   assign err_o[1] = bus1.err;
  assign rty_o[0] = bus0.rty;   assign rty_o[1] = bus1.rty;
  assign inta_o[0] = bus0.inta; assign inta_o[1] = bus1.inta;

  typedef struct {
    logic        ack;
    logic        err;
    logic [15:0] din;
  } exp_t;
  exp_t sb [$];

  int tests = 0;
  int fails = 0;

`ifdef WB_REG_SLAVE_ERR_EN
  localparam bit OOR_ACK = 1'b0;
  localparam bit OOR_ERR = 1'b1;
`else
  localparam bit OOR_ACK = 1'b1;
  localparam bit OOR_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [15:0] wd,
                      input logic [1:0] s, input bit e_ack, input bit e_err,
                      input logic [15:0] e_din, input string tag);
    int   n;
    bit   done;
    exp_t e;
    sb.push_back('{ack: e_ack, err: e_err, din: e_din});
    @(posedge clk); #1;
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
    we_v = w; adr_v = a; dout_v = wd; sel_v = s;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_o[d] || err_o[d]) done = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(n), (d == 0) ? 32'd3 : 32'd5);
    check({tag, "_ack"}, 32'(ack_o[d]), 32'(e.ack));
    check({tag, "_err"}, 32'(err_o[d]), 32'(e.err));
    check({tag, "_din"}, 32'(din_o[d]), 32'(e.din));
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
    @(negedge clk);
    check({tag, "_end"}, {15'd0, ack_o[d], err_o[d], din_o[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    cyc_v[0] = 1'b0; cyc_v[1] = 1'b0;
    stb_v[0] = 1'b0; stb_v[1] = 1'b0;
    we_v = 1'b0; adr_v = '0; dout_v = '0; sel_v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_din",  32'(din_o[0]), 32'd0);
    check("rst_ack",  32'(ack_o[0]), 32'd0);
    check("rst_err",  32'(err_o[0]), 32'd0);
    check("rst_rty",  32'(rty_o[0]), 32'd0);
    check("rst_inta", 32'(inta_o[0]), 32'd0);

    xfer(0, 1'b0, 32'd0, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0000, "rd0");
    check("rd0_inta", 32'(inta_o[0]), 32'd0);

    xfer(0, 1'b1, 32'd2, 16'hBEEF, 2'b11, 1'b1, 1'b0, 16'h0000, "wr2");
    check("wr2_inta", 32'(inta_o[0]), 32'd1);
    xfer(0, 1'b0, 32'd2, 16'h0, 2'b00, 1'b1, 1'b0, 16'hBEEF, "rd2");
    xfer(0, 1'b0, 32'd7, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0004, "rdst_a");

    xfer(0, 1'b1, 32'd3, 16'hBEEF, 2'b11, 1'b1, 1'b0, 16'h0000, "wr3a");
    xfer(0, 1'b1, 32'd3, 16'h1234, 2'b01, 1'b1, 1'b0, 16'h0000, "wr3b");
    xfer(0, 1'b0, 32'd3, 16'h0, 2'b10, 1'b1, 1'b0, 16'hBE34, "rd3");
    xfer(0, 1'b0, 32'd7, 16'h0, 2'b00, 1'b1, 1'b0, 16'h000C, "rdst_b");
    xfer(0, 1'b1, 32'd7, 16'h0008, 2'b11, 1'b1, 1'b0, 16'h0000, "clrst");
    xfer(0, 1'b0, 32'd7, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0004, "rdst_c");
    check("clrst_inta", 32'(inta_o[0]), 32'd1);

    xfer(0, 1'b1, 32'h20, 16'hFFFF, 2'b11, OOR_ACK, OOR_ERR, 16'h0000, "oor_wr");
    xfer(0, 1'b0, 32'h20, 16'h0, 2'b11, OOR_ACK, OOR_ERR, 16'h0000, "oor_rd");
    xfer(0, 1'b0, 32'd2, 16'h0, 2'b00, 1'b1, 1'b0, 16'hBEEF, "rd2_post");
    xfer(0, 1'b0, 32'd7, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0004, "rdst_post");

    @(posedge clk); #1;
    cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
    we_v = 1'b1; adr_v = 32'd4; dout_v = 16'hA5A5; sel_v = 2'b11;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_out", {14'd0, ack_o[0], err_o[0], din_o[0]}, 32'd0);
    check("rstmid_inta", 32'(inta_o[0]), 32'd0);
    @(posedge clk); #1;
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_o[0] || err_o[0]) seen = 1'b1;
    end
    check("rstmid_noack", 32'(seen), 32'd0);
    xfer(0, 1'b0, 32'd4, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0000, "rd4");
    xfer(0, 1'b0, 32'd2, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0000, "rd2_rst");

    @(posedge clk); #1;
    cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
    we_v = 1'b1; adr_v = 32'd1; dout_v = 16'h5555; sel_v = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack_o[1] || err_o[1]) seen = 1'b1;
    end
    check("abort_noack", 32'(seen), 32'd0);
    check("abort_inta", 32'(inta_o[1]), 32'd0);
    xfer(1, 1'b0, 32'd1, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0000, "ws3_rd1");
    xfer(1, 1'b1, 32'd5, 16'hC3C3, 2'b10, 1'b1, 1'b0, 16'h0000, "ws3_wr5");
    xfer(1, 1'b0, 32'd5, 16'h0, 2'b00, 1'b1, 1'b0, 16'hC300, "ws3_rd5");
    xfer(1, 1'b0, 32'd7, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0020, "ws3_rdst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
